// File: rtl/branch_ctrl_unit.sv
// -----------------------------------------------------------------------------
// branch_ctrl_unit
//   EX-stage branch/jump resolution controller. When a taken branch or jump
//   resolves in IDLE, the controller captures the target and walks through
//   REDIRECT (1 cycle, PC select + flushes) and FLUSH (FLUSH_CYCLES-1 unstalled
//   cycles, flushes only) before returning to IDLE. Instructions seen outside
//   IDLE are wrong-path and ignored. Two saturating statistics counters track
//   resolved and taken control-flow instructions.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   Valid_i          EX instruction valid
//   Branch_Signal_i  EX instruction is a conditional branch
//   Jump_i           EX instruction is an unconditional jump
//   Zero_i           ALU zero flag
//   Funct3_i         branch funct3 (bit 0: BEQ=0 / BNE=1)
//   Target_i         resolved target address
//   Stall_i          pipeline stall, freezes the controller
//   Clr_Count_i      synchronous clear of both counters
//   PCSrc_o          select Target_o as next PC
//   Target_o         registered redirect address
//   Flush_IFID_o     flush IF/ID
//   Flush_IDEX_o     flush ID/EX
//   Busy_o           controller not in IDLE
//   Branch_Count_o   resolved branch+jump count (saturating)
//   Taken_Count_o    taken branch+jump count (saturating)
// -----------------------------------------------------------------------------
module branch_ctrl_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Valid_i,
  input  logic             Branch_Signal_i,
  input  logic             Jump_i,
  input  logic             Zero_i,
  input  logic [2:0]       Funct3_i,
  input  logic [31:0]      Target_i,
  input  logic             Stall_i,
  input  logic             Clr_Count_i,
  output logic             PCSrc_o,
  output logic [31:0]      Target_o,
  output logic             Flush_IFID_o,
  output logic             Flush_IDEX_o,
  output logic             Busy_o,
  output logic [CNT_W-1:0] Branch_Count_o,
  output logic [CNT_W-1:0] Taken_Count_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      target_q, target_d;
  logic             pcsrc_q, pcsrc_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  logic is_cf;
  logic taken;
  logic accept;

  assign is_cf  = Valid_i & (Branch_Signal_i | Jump_i);
  // A jump is always taken; a branch is taken when zero disagrees with BNE.
  assign taken  = Valid_i & (Jump_i | (Branch_Signal_i & (Zero_i ^ Funct3_i[0])));
  // Only IDLE, unstalled cycles resolve instructions; others are wrong-path.
  assign accept = (state_q == IDLE) & ~Stall_i;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (taken && !Stall_i) begin
          target_d = Target_i;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        if (!Stall_i) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (!Stall_i) begin
          // Leave on the cycle the remaining count reaches zero.
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they change
    // together with the state and never follow inputs combinationally.
    pcsrc_d = (state_d == REDIRECT);
    busy_d  = (state_d != IDLE);
  end

  // Clear has priority over increment; increments stop at all-ones.
  always_comb begin
    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (Clr_Count_i) begin
      bcnt_d = '0;
      tcnt_d = '0;
    end else if (accept) begin
      if (is_cf && (bcnt_q != CNT_MAX)) bcnt_d = bcnt_q + 1'b1;
      if (taken && (tcnt_q != CNT_MAX)) tcnt_d = tcnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      target_q <= 32'h0;
      pcsrc_q  <= 1'b0;
      busy_q   <= 1'b0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pcsrc_q  <= pcsrc_d;
      busy_q   <= busy_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign PCSrc_o        = pcsrc_q;
  assign Target_o       = target_q;
  assign Flush_IFID_o   = busy_q;
  assign Flush_IDEX_o   = busy_q;
  assign Busy_o         = busy_q;
  assign Branch_Count_o = bcnt_q;
  assign Taken_Count_o  = tcnt_q;

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl_unit
//   Directed bench for branch_ctrl_unit (FLUSH_CYCLES=2, CNT_W=4). Inputs are
//   driven 1 ns after a rising edge; outputs are sampled at that same point,
//   i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_branch_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, br, jmp, zero, stall, clr;
  logic [2:0]  f3;
  logic [31:0] tgt;
  logic        pcsrc, fl_ifid, fl_idex, busy;
  logic [31:0] tgt_o;
  logic [3:0]  bcnt, tcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .Valid_i        (valid),
    .Branch_Signal_i(br),
    .Jump_i         (jmp),
    .Zero_i         (zero),
    .Funct3_i       (f3),
    .Target_i       (tgt),
    .Stall_i        (stall),
    .Clr_Count_i    (clr),
    .PCSrc_o        (pcsrc),
    .Target_o       (tgt_o),
    .Flush_IFID_o   (fl_ifid),
    .Flush_IDEX_o   (fl_idex),
    .Busy_o         (busy),
    .Branch_Count_o (bcnt),
    .Taken_Count_o  (tcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Control outputs plus both counters in one call.
  task automatic chk(input string tag, input logic pc, input logic fl,
                     input logic [3:0] eb, input logic [3:0] et);
    check({tag, ".pcsrc"}, {31'b0, pcsrc}, {31'b0, pc});
    check({tag, ".flush_ifid"}, {31'b0, fl_ifid}, {31'b0, fl});
    check({tag, ".flush_idex"}, {31'b0, fl_idex}, {31'b0, fl});
    check({tag, ".busy"}, {31'b0, busy}, {31'b0, fl});
    check({tag, ".branch_cnt"}, {28'b0, bcnt}, {28'b0, eb});
    check({tag, ".taken_cnt"}, {28'b0, tcnt}, {28'b0, et});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 0; br = 0; jmp = 0; zero = 0; f3 = 3'd0; stall = 0; clr = 0;
  endtask

  // Taken BEQ (zero=1) to address a.
  task automatic beq_taken(input logic [31:0] a);
    valid = 1; br = 1; jmp = 0; zero = 1; f3 = 3'd0; tgt = a;
  endtask

  initial begin
    idle_in();
    tgt = 32'h0;
    rst = 1'b1;
    #12;
    // Reset state
    chk("reset", 0, 0, 4'd0, 4'd0);
    check("reset.target", tgt_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Taken BEQ, 1-cycle latency to redirect, FLUSH_CYCLES=2
    beq_taken(32'h0000_0040);
    tick();
    idle_in();
    chk("beq.redirect", 1, 1, 4'd1, 4'd1);
    check("beq.target", tgt_o, 32'h40);
    tick();
    chk("beq.flush", 0, 1, 4'd1, 4'd1);
    tick();
    chk("beq.idle", 0, 0, 4'd1, 4'd1);
    check("beq.target_hold", tgt_o, 32'h40);

    // BNE with zero=1: not taken, counted as resolved
    valid = 1; br = 1; zero = 1; f3 = 3'd1; tgt = 32'h0000_0099;
    tick();
    idle_in();
    chk("bne_nt", 0, 0, 4'd2, 4'd1);
    check("bne_nt.target", tgt_o, 32'h40);

    // Taken branch with Valid_i low: nothing happens
    beq_taken(32'h0000_0055);
    valid = 0;
    tick();
    idle_in();
    chk("invalid", 0, 0, 4'd2, 4'd1);

    // Taken branch under stall in IDLE: held off, not counted
    beq_taken(32'h0000_0066);
    stall = 1;
    tick();
    chk("idle_stall", 0, 0, 4'd2, 4'd1);
    idle_in();

    // Taken branch, 3 stalled cycles in REDIRECT: PCSrc high 4 cycles
    beq_taken(32'h0000_0080);
    tick();
    idle_in();
    chk("stall.redirect0", 1, 1, 4'd3, 4'd2);
    stall = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("stall.redirect%0d", i), 1, 1, 4'd3, 4'd2);
    end
    check("stall.target", tgt_o, 32'h80);
    stall = 0;
    tick();
    chk("stall.flush", 0, 1, 4'd3, 4'd2);
    tick();
    chk("stall.idle", 0, 0, 4'd3, 4'd2);

    // Jump; wrong-path jump during FLUSH ignored; stall inside FLUSH holds it
    valid = 1; jmp = 1; tgt = 32'h0000_0100;
    tick();
    idle_in();
    chk("jmp.redirect", 1, 1, 4'd4, 4'd3);
    tick();
    chk("jmp.flush", 0, 1, 4'd4, 4'd3);
    stall = 1;
    tick();
    chk("jmp.flush_stall", 0, 1, 4'd4, 4'd3);
    stall = 0;
    valid = 1; jmp = 1; tgt = 32'h0000_0200;
    tick();
    idle_in();
    chk("jmp.wrongpath_idle", 0, 0, 4'd4, 4'd3);
    check("jmp.target_kept", tgt_o, 32'h100);

    // Branch and jump together: counted once, taken despite branch untaken
    valid = 1; br = 1; jmp = 1; zero = 0; f3 = 3'd0; tgt = 32'h0000_0300;
    tick();
    idle_in();
    chk("brjmp.redirect", 1, 1, 4'd5, 4'd4);
    check("brjmp.target", tgt_o, 32'h300);
    tick();
    tick();
    chk("brjmp.idle", 0, 0, 4'd5, 4'd4);

    // 17 more taken branches saturate both 4-bit counters
    for (int i = 0; i < 17; i++) begin
      beq_taken(32'h1000 + 32'(i));
      tick();
      idle_in();
      tick();
      tick();
    end
    chk("sat", 0, 0, 4'hF, 4'hF);
    check("sat.target", tgt_o, 32'h1010);

    // Clear coincident with a taken branch: counters zero, FSM still redirects
    beq_taken(32'h0000_0500);
    clr = 1;
    tick();
    idle_in();
    chk("clr.redirect", 1, 1, 4'd0, 4'd0);
    check("clr.target", tgt_o, 32'h500);
    tick();

    // Asynchronous reset mid-FLUSH, then normal resolution afterwards
    chk("pre_rst.flush", 0, 1, 4'd0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.async", 0, 0, 4'd0, 4'd0);
    check("rst.target", tgt_o, 32'h0);
    #3;
    rst = 1'b0;
    tick();
    chk("rst.after", 0, 0, 4'd0, 4'd0);
    beq_taken(32'h0000_0044);
    tick();
    idle_in();
    chk("rst.redirect", 1, 1, 4'd1, 4'd1);
    check("rst.redirect_target", tgt_o, 32'h44);
    tick();
    tick();
    chk("rst.idle", 0, 0, 4'd1, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl_unit.md
BRANCH_CTRL_UNIT -- requirements
Module: branch_ctrl_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles the front-end flush is held after a taken branch/jump (legal 1..7).
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Valid_i  input  1  EX-stage instruction valid.
REQ-006 Branch_Signal_i  input  1  EX instruction is a conditional branch.
REQ-007 Jump_i  input  1  EX instruction is an unconditional jump (JAL/JALR).
REQ-008 Zero_i  input  1  ALU zero flag for the EX instruction.
REQ-009 Funct3_i  input  3  branch funct3; bit 0 selects BEQ (0) / BNE (1).
REQ-010 Target_i  input  32  resolved branch/jump target address.
REQ-011 Stall_i  input  1  pipeline stall; freezes the controller.
REQ-012 Clr_Count_i  input  1  synchronous clear of both statistics counters.
REQ-013 PCSrc_o  output  1  select Target_o as next PC.
REQ-014 Target_o  output  32  registered redirect address.
REQ-015 Flush_IFID_o  output  1  flush IF/ID register.
REQ-016 Flush_IDEX_o  output  1  flush ID/EX register.
REQ-017 Busy_o  output  1  controller not in IDLE.
REQ-018 Branch_Count_o  output  CNT_W  resolved branch+jump count.
REQ-019 Taken_Count_o  output  CNT_W  taken branch+jump count.

Function
REQ-020 taken SHALL equal Valid_i & (Jump_i | (Branch_Signal_i & (Zero_i ^ Funct3_i[0]))).
REQ-021 FSM states SHALL be IDLE, REDIRECT, FLUSH; Busy_o = (state != IDLE).
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-023 IDLE: if taken & !Stall_i, capture Target_i into Target_o and go to REDIRECT next cycle; otherwise stay IDLE.
REQ-024 REDIRECT: PCSrc_o=1, Flush_IFID_o=1, Flush_IDEX_o=1; latency from sampling taken to PCSrc_o high is exactly 1 cycle.
REQ-025 REDIRECT with Stall_i=1 SHALL hold state and all outputs unchanged.
REQ-026 REDIRECT with Stall_i=0: go to FLUSH if FLUSH_CYCLES>1, else IDLE.
REQ-027 FLUSH: PCSrc_o=0, both flush outputs=1; remaining-cycle counter loaded with FLUSH_CYCLES-1 on REDIRECT exit, decrements only when Stall_i=0, exit to IDLE when it reaches 0 on an unstalled cycle.
REQ-028 In IDLE all of PCSrc_o, Flush_IFID_o, Flush_IDEX_o SHALL be 0; Target_o holds its last value.
REQ-029 Valid_i/Branch/Jump inputs in REDIRECT or FLUSH SHALL be ignored (wrong-path instructions): no state change, no counter update.
REQ-030 Branch_Count_o SHALL increment by 1 when state=IDLE, Valid_i & (Branch_Signal_i | Jump_i), Stall_i=0.
REQ-031 Taken_Count_o SHALL increment by 1 when state=IDLE, taken, Stall_i=0.
REQ-032 Both counters SHALL saturate at all-ones (no wrap).
REQ-033 Clr_Count_i=1 SHALL zero both counters next cycle; clear wins over simultaneous increment; FSM unaffected.
REQ-034 Branch_Signal_i and Jump_i both high SHALL count once and be treated as taken.

Reset
REQ-035 rst_i high SHALL immediately force state IDLE, flush counter 0, PCSrc_o=0, Flush_IFID_o=0, Flush_IDEX_o=0, Busy_o=0, Target_o=32'h0, both counters 0.
REQ-036 Reset asserted in REDIRECT or FLUSH SHALL abort the sequence; after release, first taken resolution behaves per REQ-023.

Verification
REQ-037 BEQ Zero_i=1, Target_i=32'h0000_0040, FLUSH_CYCLES=2 -> next cycle PCSrc_o=1, Target_o=0x40, flushes=1; following cycle PCSrc_o=0, flushes=1; then IDLE; Branch_Count=1, Taken_Count=1.
REQ-038 BNE Zero_i=1 -> no redirect, flushes stay 0, Branch_Count=1, Taken_Count=0.
REQ-039 Taken branch, Stall_i=1 for 3 cycles during REDIRECT -> PCSrc_o held high 4 cycles total, then FLUSH proceeds normally.
REQ-040 Jump_i=1 during FLUSH with Valid_i=1 -> ignored, counters unchanged, returns IDLE on schedule.
REQ-041 CNT_W=4, 17 taken branches -> both counters read 4'hF; Clr_Count_i coincident with a taken branch -> counters 0.
REQ-042 rst_i pulsed mid-FLUSH (asynchronously, between edges) -> outputs zero immediately, Busy_o=0, Target_o=0.
